// File: rtl/fir_coef_loader.sv
// fir_coef_loader: buffers FIR coefficient writes per filter/tap and drains them to a coefficient RAM.
// Define COEF_CHECKSUM_EN to enable the running XOR checksum of accepted coefficients.
module fir_coef_loader #(
    parameter int num_of_filters = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int FW = (num_of_filters > 1) ? $clog2(num_of_filters) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          coef_wr_stb,
    input  logic [7:0]    coef_lsb,
    input  logic [7:0]    coef_msb,
    input  logic [7:0]    filter_select,
    input  logic [7:0]    taps_per_filter,
    input  logic          ptr_clr,
    input  logic          err_clr,
    input  logic          ram_ready,
    output logic          coef_ram_we,
    output logic [FW+7:0] coef_ram_addr,
    output logic [15:0]   coef_ram_data,
    output logic [7:0]    tap_ptr,
    output logic          filter_loaded,
    output logic [2:0]    err_flags,
    output logic [15:0]   coef_checksum
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = FW + 24;
    localparam logic [8:0] NF = 9'(num_of_filters);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {EMPTY, LOADING, FULL} tap_state_t;

    tap_state_t    state, eff_state;
    logic [7:0]    eff_ptr, tap_ptr_next;
    logic          sel_ok, sel_err, overrun_err, fifo_ovf, push, pop, fifo_full, fifo_empty;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // ptr_clr takes effect before a coincident strobe is judged, so acceptance uses eff_ptr
    always_comb begin
        state        = (tap_ptr >= taps_per_filter) ? FULL : (tap_ptr == 8'd0) ? EMPTY : LOADING;
        eff_ptr      = ptr_clr ? 8'd0 : tap_ptr;
        eff_state    = (eff_ptr >= taps_per_filter) ? FULL : (eff_ptr == 8'd0) ? EMPTY : LOADING;
        sel_ok       = {1'b0, filter_select} < NF;
        sel_err      = coef_wr_stb && !sel_ok;
        overrun_err  = coef_wr_stb && sel_ok && eff_state == FULL;
        fifo_ovf     = coef_wr_stb && sel_ok && eff_state != FULL && fifo_full;
        push         = coef_wr_stb && sel_ok && eff_state != FULL && !fifo_full;
        tap_ptr_next = push ? eff_ptr + 8'd1 : eff_ptr;
    end

    assign filter_loaded = state == FULL;
    assign fifo_full     = count == DEPTH_C;
    assign fifo_empty    = count == '0;
    assign pop           = !fifo_empty && ram_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {filter_select[FW-1:0], eff_ptr, coef_msb, coef_lsb};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_ptr       <= '0;
            err_flags     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            coef_ram_we   <= 1'b0;
            coef_ram_addr <= '0;
            coef_ram_data <= '0;
        end else begin
            tap_ptr     <= tap_ptr_next;
            err_flags   <= (err_clr ? 3'b000 : err_flags) | {sel_err, overrun_err, fifo_ovf};
            wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count       <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            coef_ram_we <= pop;
            if (pop) {coef_ram_addr, coef_ram_data} <= mem[rd_ptr];
        end
    end

`ifdef COEF_CHECKSUM_EN
    logic [15:0] csum;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) csum <= '0;
        else       csum <= (ptr_clr ? 16'h0 : csum) ^ (push ? {coef_msb, coef_lsb} : 16'h0);
    end
    assign coef_checksum = csum;
`else
    assign coef_checksum = 16'h0000;
`endif
endmodule
